// File: rtl/dblbuf_arb_pkg.sv
// Shared types and constants for the round-robin double-buffer arbiter.
package dblbuf_arb_pkg;

    localparam int N_DEF = 4;
    localparam int W_DEF = 32;
    localparam int DEPTH = 2;

    // Types for the default configuration; parameterised instances build their own.
    typedef logic [$clog2(N_DEF)-1:0] id_t;

    typedef struct packed {
        logic [W_DEF-1:0] data;
        id_t              id;
    } entry_t;

    typedef logic [$clog2(DEPTH+1)-1:0] cnt_t;

endpackage

// File: rtl/dblbuf_arb_rr.sv
// Rotating-priority pick: first set candidate at or above ptr, wrapping N-1 -> 0.
module dblbuf_arb_rr #(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   cand,
    input  logic [IDW-1:0] ptr,
    output logic           found,
    output logic [IDW-1:0] winner
);

    localparam int IDW1 = IDW + 1;
    localparam logic [IDW:0] N_W = IDW1'(N);

    logic [IDW:0]   sum;
    logic [IDW-1:0] idx;

    // NOTE: every output gets a default before the loop so no latch is inferred.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        sum    = '0;
        idx    = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, ptr} + IDW1'(k);
            if (sum >= N_W) sum = sum - N_W;
            idx = sum[IDW-1:0];
            if (!found && cand[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/dblbuf_arb.sv
// N-way round-robin arbiter feeding a shared 2-entry buffer with a single valid/accept output.
module dblbuf_arb
    import dblbuf_arb_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         A__in_vld_r,
    input  logic [N*W-1:0]       A__in_w,
    output logic [N-1:0]         A__in_accept_r,
    input  logic                 B__out_accept_r,
    output logic                 B__out_vld_r,
    output logic [W-1:0]         B__out_r,
    output logic [$clog2(N)-1:0] B__out_id_r,
    input  logic                 stall_req
);

    localparam int IDW = $clog2(N);

    typedef struct packed {
        logic [W-1:0]   data;
        logic [IDW-1:0] id;
    } slot_t;

    slot_t          ent0_q, ent0_d, ent1_q, ent1_d, push_slot;
    cnt_t           cnt_q, cnt_d, cnt_pop;
    logic [IDW-1:0] ptr_q, ptr_d, winner;
    logic [N-1:0]   acc_q, acc_d, xfer, cand;
    logic           push, pop, found, credit, grant;

    assign xfer = acc_q & A__in_vld_r;
    assign push = |xfer;
    assign pop  = (cnt_q != '0) & B__out_accept_r;

    always_comb begin
        push_slot = '0;
        for (int i = 0; i < N; i++) begin
            if (acc_q[i]) begin
                push_slot.data = A__in_w[i*W +: W];
                push_slot.id   = IDW'(i);
            end
        end
    end

    // Pop shifts entry 1 down first, so a simultaneous push lands at the new tail.
    always_comb begin
        ent0_d  = ent0_q;
        ent1_d  = ent1_q;
        cnt_pop = cnt_q;
        if (pop) begin
            ent0_d  = ent1_q;
            cnt_pop = cnt_q - cnt_t'(1);
        end
        if (push) begin
            if (cnt_pop == '0) ent0_d = push_slot;
            else               ent1_d = push_slot;
        end
        cnt_d = cnt_pop + cnt_t'(push);
    end

    // The transferring requester's vld still describes the word just taken, so mask it.
    assign cand = A__in_vld_r & ~xfer;

    dblbuf_arb_rr #(.N(N), .IDW(IDW)) u_rr (
        .cand   (cand),
        .ptr    (ptr_q),
        .found  (found),
        .winner (winner)
    );

    assign credit = (cnt_d < cnt_t'(DEPTH)) & ~stall_req;
    assign grant  = found & credit;

    always_comb begin
        acc_d = '0;
        ptr_d = ptr_q;
        if (grant) begin
            acc_d[winner] = 1'b1;
            ptr_d         = (winner == IDW'(N-1)) ? '0 : winner + IDW'(1);
        end
    end

    // NOTE: state updates use non-blocking assignments so all flops see pre-edge values.
    // NOTE: the two buffer entries are reset too; they are flops, not a RAM macro.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent0_q <= '0;
            ent1_q <= '0;
            cnt_q  <= '0;
            ptr_q  <= '0;
            acc_q  <= '0;
        end else begin
            ent0_q <= ent0_d;
            ent1_q <= ent1_d;
            cnt_q  <= cnt_d;
            ptr_q  <= ptr_d;
            acc_q  <= acc_d;
        end
    end

    assign A__in_accept_r = acc_q;
    assign B__out_vld_r   = (cnt_q != '0);
    assign B__out_r       = ent0_q.data;
    assign B__out_id_r    = ent0_q.id;

    a_accept_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(acc_q));
    a_cnt_bound: assert property (@(posedge clk) disable iff (!rst_n)
        cnt_q <= cnt_t'(DEPTH));
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && cnt_q == cnt_t'(DEPTH) && !pop));

    for (genvar gi = 0; gi < N; gi++) begin : g_stable
        a_req_stable: assert property (@(posedge clk) disable iff (!rst_n)
            (A__in_vld_r[gi] && !acc_q[gi]) |=>
            (A__in_vld_r[gi] && $stable(A__in_w[gi*W +: W])));
    end

endmodule

// File: tb/tb_dblbuf_arb.sv
// Directed self-checking bench for dblbuf_arb: N=4 requesters, W=32.
module tb_dblbuf_arb;

    localparam int N   = 4;
    localparam int W   = 32;
    localparam int IDW = 2;

    localparam logic [N-1:0]   T4_ACC  [10] = '{4'h0, 4'h1, 4'h2, 4'h0, 4'h0, 4'h0, 4'h4, 4'h0, 4'h0, 4'h8};
    localparam logic           T4_BACC [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    localparam logic [W-1:0]   T4_DATA [10] = '{32'h0, 32'h0, 32'hA0, 32'hA0, 32'hA0, 32'hA0, 32'hB0, 32'hB0, 32'hB0, 32'hC0};
    localparam logic [IDW-1:0] T4_ID   [10] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2};

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   vld;
    logic [N*W-1:0] a_w;
    logic [N-1:0]   acc;
    logic           b_acc;
    logic           out_vld;
    logic [W-1:0]   out_d;
    logic [IDW-1:0] out_id;
    logic           stall;

    int n_assert = 0;
    int n_fail   = 0;
    int sent [N];
    int lim  [N];

    dblbuf_arb #(.N(N), .W(W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .A__in_vld_r     (vld),
        .A__in_w         (a_w),
        .A__in_accept_r  (acc),
        .B__out_accept_r (b_acc),
        .B__out_vld_r    (out_vld),
        .B__out_r        (out_d),
        .B__out_id_r     (out_id),
        .stall_req       (stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] gen(input int i, input int n);
        return 32'hA0 + W'(16 * i + n);
    endfunction

    function automatic logic [N-1:0] oh(input int i);
        logic [N-1:0] r;
        r    = '0;
        r[i] = 1'b1;
        return r;
    endfunction

    // Producer model: a requester advances to its next word after a transfer.
    task automatic tick();
        logic [N-1:0] x;
        x = acc & vld;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (x[i]) begin
                sent[i]++;
                if (sent[i] < lim[i]) a_w[i*W +: W] = gen(i, sent[i]);
                else                  vld[i] = 1'b0;
            end
        end
    endtask

    task automatic start(input logic [N-1:0] mask, input int l);
        for (int i = 0; i < N; i++) begin
            if (mask[i]) begin
                sent[i]       = 0;
                lim[i]        = l;
                vld[i]        = 1'b1;
                a_w[i*W +: W] = gen(i, 0);
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        vld   = '0;
        a_w   = '0;
        stall = 1'b0;
        b_acc = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        vld   = '0;
        a_w   = '0;
        b_acc = 1'b0;
        stall = 1'b0;
        for (int i = 0; i < N; i++) begin
            sent[i] = 0;
            lim[i]  = 0;
        end
        @(negedge clk);
        do_reset();

        // Idle after reset
        check("rst_out_d", out_d, 0);
        check("rst_out_id", out_id, 0);
        for (int k = 0; k < 10; k++) begin
            check($sformatf("idle_acc_%0d", k), acc, 0);
            check($sformatf("idle_vld_%0d", k), out_vld, 0);
            tick();
        end

        // Single requester: one word every two cycles
        b_acc = 1'b1;
        start(4'b0001, 3);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("single_acc_%0d", k), acc,
                  (k % 2 == 1 && k <= 5) ? 4'b0001 : 4'b0000);
            check($sformatf("single_vld_%0d", k), out_vld, (k % 2 == 0 && k >= 2 && k <= 6));
            if (k % 2 == 0 && k >= 2 && k <= 6) begin
                check($sformatf("single_data_%0d", k), out_d, gen(0, (k - 2) / 2));
                check($sformatf("single_id_%0d", k), out_id, 0);
            end
            tick();
        end

        // All requesters valid, consumer always accepting
        do_reset();
        b_acc = 1'b1;
        start(4'b1111, 100);
        for (int k = 0; k < 10; k++) begin
            check($sformatf("full_acc_%0d", k), acc, (k >= 1) ? oh((k - 1) % 4) : 4'b0000);
            check($sformatf("full_vld_%0d", k), out_vld, (k >= 2));
            if (k >= 2) begin
                check($sformatf("full_data_%0d", k), out_d, gen((k - 2) % 4, (k - 2) / 4));
                check($sformatf("full_id_%0d", k), out_id, (k - 2) % 4);
            end
            tick();
        end

        // Consumer stalled: two transfers, then one pop frees exactly one slot
        do_reset();
        start(4'b1111, 100);
        for (int k = 0; k < 10; k++) begin
            b_acc = T4_BACC[k];
            check($sformatf("cstall_acc_%0d", k), acc, T4_ACC[k]);
            check($sformatf("cstall_vld_%0d", k), out_vld, (k >= 2));
            if (k >= 2) begin
                check($sformatf("cstall_data_%0d", k), out_d, T4_DATA[k]);
                check($sformatf("cstall_id_%0d", k), out_id, T4_ID[k]);
            end
            tick();
        end

        // stall_req over cycles 5..9
        do_reset();
        b_acc = 1'b1;
        start(4'b1111, 100);
        for (int k = 0; k < 13; k++) begin
            logic [N-1:0] e_acc;
            stall = (k >= 5 && k <= 9);
            if (k >= 1 && k <= 5) e_acc = oh((k - 1) % 4);
            else if (k == 11)     e_acc = 4'b0010;
            else if (k == 12)     e_acc = 4'b0100;
            else                  e_acc = 4'b0000;
            check($sformatf("sreq_acc_%0d", k), acc, e_acc);
            check($sformatf("sreq_vld_%0d", k), out_vld, ((k >= 2 && k <= 6) || k == 12));
            if (k >= 2 && k <= 5) begin
                check($sformatf("sreq_data_%0d", k), out_d, gen(k - 2, 0));
                check($sformatf("sreq_id_%0d", k), out_id, k - 2);
            end else if (k == 6) begin
                check("sreq_data_6", out_d, gen(0, 1));
                check("sreq_id_6", out_id, 0);
            end else if (k == 12) begin
                check("sreq_data_12", out_d, gen(1, 1));
                check("sreq_id_12", out_id, 1);
            end
            tick();
        end

        // Asynchronous reset mid-stream
        do_reset();
        start(4'b1111, 100);
        tick();
        tick();
        check("arst_pre_acc", acc, 4'b0010);
        check("arst_pre_vld", out_vld, 1);
        rst_n = 1'b0;
        #1;
        check("arst_acc", acc, 0);
        check("arst_vld", out_vld, 0);
        check("arst_data", out_d, 0);
        check("arst_id", out_id, 0);
        @(negedge clk);
        check("arst_hold_vld", out_vld, 0);
        check("arst_hold_acc", acc, 0);
        rst_n = 1'b1;
        check("arst_rel_acc", acc, 0);
        tick();
        check("arst_first_grant", acc, 4'b0001);
        tick();
        check("arst_second_grant", acc, 4'b0010);
        check("arst_out_vld", out_vld, 1);
        check("arst_out_data", out_d, gen(0, 1));
        check("arst_out_id", out_id, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
